// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-tenure hold limit and a forced-release pulse.
// Latency: grant is visible one cycle after the arbitration edge; all outputs come from registers.
// Backpressure: none; an owner keeps the resource while Req stays high, up to MAX_HOLD cycles.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Req,
   output logic [3:0] Grant,
   output logic [1:0] GrantIdx,
   output logic       Valid,
   output logic       Preempt
);

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         LIMIT_EN = (MAX_HOLD != 0);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [3:0] grant, grant_nxt;
   logic       pre, pre_nxt;

   logic       release_ev;
   logic       limit_ev;
   logic       arb;
   logic       win_found;
   logic [1:0] win;
   logic [1:0] cand;

   // Rotating-priority search: walk from the lowest priority back to Ptr so the
   // highest-priority requester is the last one written and therefore wins.
   always_comb begin
      win_found = 1'b0;
      win       = ptr;
      cand      = ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (Req[cand]) begin
            win_found = 1'b1;
            win       = cand;
         end
      end
   end

   // Next-state logic: decide whether this edge is an arbitration point, then
   // either hand the resource to the winner or extend the current tenure.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      grant_nxt = grant;
      pre_nxt   = 1'b0;

      release_ev = (state == BUSY) && !Req[idx];
      limit_ev   = (state == BUSY) && LIMIT_EN && (cnt == HOLD_LIM);
      arb        = (state == IDLE) || release_ev || limit_ev;

      if (arb) begin
         // A release in the same cycle as the limit counts as a release.
         pre_nxt = limit_ev && !release_ev;
         if (win_found) begin
            state_nxt = BUSY;
            idx_nxt   = win;
            ptr_nxt   = win + 2'd1;
            cnt_nxt   = 8'd1;
            grant_nxt = 4'b0001 << win;
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            grant_nxt = 4'b0000;
         end
      end else if (cnt != 8'hFF) begin
         // Saturate so an unlimited tenure can never roll the counter over.
         cnt_nxt = cnt + 8'd1;
      end
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 2'b00;
         ptr   <= 2'b00;
         cnt   <= 8'd0;
         grant <= 4'b0000;
         pre   <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         grant <= grant_nxt;
         pre   <= pre_nxt;
      end
   end

   assign Grant    = grant;
   assign GrantIdx = idx;
   assign Valid    = (state == BUSY);
   assign Preempt  = pre;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench: four arbiters with different hold limits share one stimulus stream.
// Each cycle every instance is compared with a tenure-level reference model.
// Directed scenarios add hard-coded expectations on the instance whose limit they target.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic [3:0] req;

   logic [3:0] a_grant [4];
   logic [1:0] a_idx   [4];
   logic       a_valid [4];
   logic       a_pre   [4];

   // Instance d uses hold limit mh[d]: 4, 0 (disabled), 3, 16.
   int mh [4] = '{4, 0, 3, 16};

   for (genvar g = 0; g < 4; g++) begin : g_dut
      rr_arbiter4 #(
         .MAX_HOLD(g == 0 ? 4 : g == 1 ? 0 : g == 2 ? 3 : 16)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .Req      (req),
         .Grant    (a_grant[g]),
         .GrantIdx (a_idx[g]),
         .Valid    (a_valid[g]),
         .Preempt  (a_pre[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: owner (-1 when none), priority pointer, tenure length so far.
   int owner [4];
   int ptr_m [4];
   int len   [4];
   bit pre_m [4];

   function automatic logic [7:0] exp_vec(int d);
      logic       v;
      logic [3:0] g;
      logic [1:0] i;
      v = (owner[d] >= 0);
      g = v ? 4'(1 << owner[d]) : 4'b0000;
      i = v ? 2'(owner[d]) : 2'b00;
      return {v, g, i, pre_m[d]};
   endfunction

   function automatic logic [7:0] act_vec(int d);
      return {a_valid[d], a_grant[d], (a_valid[d] ? a_idx[d] : 2'b00), a_pre[d]};
   endfunction

   // Advance one clock edge and apply the arbitration rules to the model.
   task automatic tick();
      @(posedge clk);
      for (int d = 0; d < 4; d++) begin
         if (rst) begin
            owner[d] = -1; ptr_m[d] = 0; len[d] = 0; pre_m[d] = 1'b0;
         end else begin
            bit rel, lim;
            rel = (owner[d] >= 0) && !req[owner[d]];
            lim = (owner[d] >= 0) && (mh[d] != 0) && (len[d] == mh[d]);
            if (owner[d] < 0 || rel || lim) begin
               int w;
               w = -1;
               pre_m[d] = lim && !rel;
               for (int k = 0; k < 4; k++)
                  if (w < 0 && req[(ptr_m[d] + k) % 4]) w = (ptr_m[d] + k) % 4;
               if (w >= 0) begin
                  owner[d] = w; len[d] = 1; ptr_m[d] = (w + 1) % 4;
               end else begin
                  owner[d] = -1; len[d] = 0;
               end
            end else begin
               len[d]++;
               pre_m[d] = 1'b0;
            end
         end
      end
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      tick();
      tick();
      for (int d = 0; d < 4; d++) begin
         tests++;
         if ({a_grant[d], a_idx[d], a_valid[d], a_pre[d]} !== 8'b0) begin
            errors++;
            $display("FAIL reset dut%0d got grant=%b idx=%b valid=%b pre=%b exp all zero",
                     d, a_grant[d], a_idx[d], a_valid[d], a_pre[d]);
         end
      end
      rst = 1'b0;
      req = 4'b0000;
      tick();
   endtask

   task automatic test_basic_handover();
      logic [3:0] seq [4] = '{4'b0101, 4'b0100, 4'b0000, 4'b1111};
      logic [3:0] exp [4] = '{4'b0001, 4'b0100, 4'b0000, 4'b1000};
      for (int s = 0; s < 4; s++) begin
         req = seq[s];
         tick();
         for (int d = 0; d < 4; d++) begin
            tests++;
            if (act_vec(d) !== exp_vec(d) || a_grant[d] !== exp[s]) begin
               errors++;
               $display("FAIL handover dut%0d step%0d got %b grant=%b exp %b grant=%b",
                        d, s, act_vec(d), a_grant[d], exp_vec(d), exp[s]);
            end
         end
      end
   endtask

   task automatic test_full_rotation();
      do_reset();
      req = 4'b1111;
      for (int c = 1; c <= 20; c++) begin
         logic [3:0] eg;
         logic       ep;
         tick();
         eg = 4'b0001 << (((c - 1) / 4) % 4);
         ep = (c > 1) && ((c - 1) % 4 == 0);
         tests++;
         if (a_grant[0] !== eg || a_pre[0] !== ep || a_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL rotation cycle%0d got grant=%b pre=%b exp grant=%b pre=%b",
                     c, a_grant[0], a_pre[0], eg, ep);
         end
         for (int d = 0; d < 4; d++) begin
            tests++;
            if (act_vec(d) !== exp_vec(d)) begin
               errors++;
               $display("FAIL rotation_model dut%0d cyc%0d got %b exp %b", d, cyc, act_vec(d), exp_vec(d));
            end
         end
      end
   endtask

   task automatic test_lone_holder();
      int pulses = 0;
      do_reset();
      req = 4'b0010;
      for (int c = 1; c <= 21; c++) begin
         tick();
         if (a_pre[0]) pulses++;
         tests++;
         if (a_grant[0] !== 4'b0010 || a_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL lone_holder cycle%0d got grant=%b valid=%b exp 0010 1", c, a_grant[0], a_valid[0]);
         end
         for (int d = 0; d < 4; d++) begin
            tests++;
            if (act_vec(d) !== exp_vec(d)) begin
               errors++;
               $display("FAIL lone_model dut%0d cyc%0d got %b exp %b", d, cyc, act_vec(d), exp_vec(d));
            end
         end
      end
      tests++;
      if (pulses !== 5) begin
         errors++;
         $display("FAIL lone_pulses got %0d exp 5", pulses);
      end
   endtask

   task automatic test_limit_disabled();
      int bad = 0;
      do_reset();
      req = 4'b1000;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (a_grant[1] !== 4'b1000 || a_pre[1] !== 1'b0) bad++;
         for (int d = 0; d < 4; d++) begin
            tests++;
            if (act_vec(d) !== exp_vec(d)) begin
               errors++;
               $display("FAIL nolimit_model dut%0d cyc%0d got %b exp %b", d, cyc, act_vec(d), exp_vec(d));
            end
         end
      end
      tests++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL nolimit_hold got %0d bad cycles exp 0", bad);
      end
      req = 4'b1001;
      tick();
      tests++;
      if (a_grant[1] !== 4'b1000) begin
         errors++;
         $display("FAIL nolimit_ignore got grant=%b exp 1000", a_grant[1]);
      end
      req = 4'b0001;
      tick();
      tests++;
      if (a_grant[1] !== 4'b0001 || a_valid[1] !== 1'b1) begin
         errors++;
         $display("FAIL nolimit_handover got grant=%b valid=%b exp 0001 1", a_grant[1], a_valid[1]);
      end
   endtask

   task automatic test_reset_mid_tenure();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b1111;
      tick();
      rst = 1'b1;
      tick();
      for (int d = 0; d < 4; d++) begin
         tests++;
         if ({a_grant[d], a_idx[d], a_valid[d], a_pre[d]} !== 8'b0) begin
            errors++;
            $display("FAIL midreset dut%0d got grant=%b idx=%b valid=%b pre=%b exp all zero",
                     d, a_grant[d], a_idx[d], a_valid[d], a_pre[d]);
         end
      end
      rst = 1'b0;
      tick();
      for (int d = 0; d < 4; d++) begin
         tests++;
         if (a_grant[d] !== 4'b0001 || act_vec(d) !== exp_vec(d)) begin
            errors++;
            $display("FAIL midreset_restart dut%0d got grant=%b exp 0001", d, a_grant[d]);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      req = 4'b0011;
      tick();
      tick();
      tick();
      req = 4'b0010;
      tick();
      tests++;
      if (a_grant[2] !== 4'b0010 || a_pre[2] !== 1'b0 || a_valid[2] !== 1'b1) begin
         errors++;
         $display("FAIL simultaneous got grant=%b pre=%b valid=%b exp 0010 0 1",
                  a_grant[2], a_pre[2], a_valid[2]);
      end
      for (int d = 0; d < 4; d++) begin
         tests++;
         if (act_vec(d) !== exp_vec(d)) begin
            errors++;
            $display("FAIL simultaneous_model dut%0d got %b exp %b", d, act_vec(d), exp_vec(d));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         tick();
         for (int d = 0; d < 4; d++) begin
            tests++;
            if (act_vec(d) !== exp_vec(d)) begin
               errors++;
               $display("FAIL random dut%0d cyc%0d req=%b got %b exp %b", d, cyc, req, act_vec(d), exp_vec(d));
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      for (int d = 0; d < 4; d++) begin
         owner[d] = -1; ptr_m[d] = 0; len[d] = 0; pre_m[d] = 1'b0;
      end
      test_reset();
      test_basic_handover();
      test_full_rotation();
      test_lone_holder();
      test_limit_disabled();
      test_reset_mid_tenure();
      test_simultaneous();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
